// File: rtl/chn_trigger.sv
// Multi-channel threshold trigger with per-channel holdoff/re-arm FSMs and a stall-tolerant hit output.
// Optional re-arm hysteresis is enabled by defining CHN_TRIGGER_HYST_EN.
module chn_trigger #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 2,
  parameter int HOLDOFF  = 4,
  parameter int HYST     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [CHANNELS*(BITS+1)-1:0] chn_values,
  input  logic signed [BITS:0]         threshold,
  output logic [CHANNELS-1:0]          hit,
  output logic                         hit_valid,
  input  logic                         hit_ready,
  output logic                         overflow,
  output logic [CHANNELS-1:0]          armed
);

  localparam int W = BITS + 1;
  localparam logic signed [BITS+1:0] HYST_L = (BITS+2)'(HYST);
`ifdef CHN_TRIGGER_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif
  localparam logic signed [BITS+1:0] HYST_EFF = HYST_EN ? HYST_L : '0;

  typedef enum logic [1:0] {ARMED, HOLD, WAIT_LOW} state_t;

  state_t                state_q [CHANNELS];
  state_t                state_d [CHANNELS];
  logic [7:0]            cnt_q   [CHANNELS];
  logic [7:0]            cnt_d   [CHANNELS];
  logic signed [BITS:0]  smp     [CHANNELS];
  logic signed [BITS+1:0] thr_ext;
  logic signed [BITS+1:0] rearm_lvl;
  logic [CHANNELS-1:0]   fire;
  logic [CHANNELS-1:0]   pend;

  // One extra bit keeps threshold-HYST from wrapping near the negative limit.
  assign thr_ext   = {threshold[BITS], threshold};
  assign rearm_lvl = thr_ext - HYST_EFF;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      smp[i] = $signed(chn_values[i*W +: W]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        state_q[i] <= ARMED;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ARMED: begin
          if (fire[i]) begin
            state_d[i] = HOLD;
            cnt_d[i]   = 8'(HOLDOFF - 1);
          end
        end
        HOLD: begin
          if (cnt_q[i] == 8'd0) state_d[i] = WAIT_LOW;
          else                  cnt_d[i]   = cnt_q[i] - 8'd1;
        end
        WAIT_LOW: begin
          if (in_valid && ($signed({smp[i][BITS], smp[i]}) < rearm_lvl)) state_d[i] = ARMED;
        end
        default: state_d[i] = ARMED;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      armed[i] = (state_q[i] == ARMED);
      fire[i]  = (state_q[i] == ARMED) && in_valid && (smp[i] >= threshold);
    end
  end

  // Handshake: a word transfers on any edge where hit_valid && hit_ready; while
  // hit_valid && !hit_ready, hit/hit_valid hold and new fires collect in pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit       <= '0;
      hit_valid <= 1'b0;
      pend      <= '0;
      overflow  <= 1'b0;
    end else if (!hit_valid) begin
      hit       <= fire;
      hit_valid <= |fire;
    end else begin
      if (|(pend & fire)) overflow <= 1'b1;
      if (hit_ready) begin
        hit       <= pend | fire;
        hit_valid <= |(pend | fire);
        pend      <= '0;
      end else begin
        pend      <= pend | fire;
      end
    end
  end

endmodule

// File: tb/tb_chn_trigger.sv
// Randomized bench for chn_trigger: a per-channel timeline model plus directed literal scenarios.
module tb_chn_trigger;
  localparam int BITS = 8;
  localparam int CH   = 2;
  localparam int HO   = 4;
  localparam int HY   = 2;
`ifdef CHN_TRIGGER_HYST_EN
  localparam int HYST_EFF = HY;
`else
  localparam int HYST_EFF = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic [CH*(BITS+1)-1:0] chn_values = '0;
  logic signed [BITS:0]   threshold = '0;
  logic [CH-1:0]          hit;
  logic                   hit_valid;
  logic                   hit_ready = 1'b0;
  logic                   overflow;
  logic [CH-1:0]          armed;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  chn_trigger #(.BITS(BITS), .CHANNELS(CH), .HOLDOFF(HO), .HYST(HY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .chn_values(chn_values),
    .threshold(threshold), .hit(hit), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .overflow(overflow), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input int s0, input int s1, input bit rdy, input bit r);
    in_valid   = v;
    chn_values = {9'(s1), 9'(s0)};
    hit_ready  = rdy;
    rst        = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: a channel fired at cycle L ignores samples until cycle L+HO+1, then
  // re-arms on the first valid sample below the re-arm level.
  bit [CH-1:0] m_armed = '1;
  int          m_last [CH];
  int          cyc = 0;
  logic [CH-1:0] m_hit = '0, m_pend = '0;
  bit          m_hv = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin : model
    logic [CH-1:0] f;
    int s, t;
    cyc++;
    if (rst) begin
      m_armed = '1; m_hit = '0; m_pend = '0; m_hv = 1'b0; m_ovf = 1'b0;
    end else begin
      t = $signed(threshold);
      f = '0;
      for (int i = 0; i < CH; i++) begin
        s = $signed(chn_values[i*(BITS+1) +: BITS+1]);
        if (m_armed[i]) begin
          if (in_valid && s >= t) begin
            f[i] = 1'b1; m_armed[i] = 1'b0; m_last[i] = cyc;
          end
        end else if (cyc > m_last[i] + HO && in_valid && s < t - HYST_EFF) begin
          m_armed[i] = 1'b1;
        end
      end
      if (!m_hv) begin
        m_hit = f; m_hv = (f != 0);
      end else begin
        if ((m_pend & f) != 0) m_ovf = 1'b1;
        m_pend = m_pend | f;
        if (hit_ready) begin
          m_hit = m_pend; m_hv = (m_pend != 0); m_pend = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_hit_valid", 32'(hit_valid), 32'(m_hv));
      if (m_hv) chk("cmp_hit", 32'(hit), 32'(m_hit));
      chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
      chk("cmp_armed", 32'(armed), 32'(m_armed));
    end
  end

  initial begin
    int t;
    step(0, 0, 0, 1, 1);
    chk_en = 1'b1;
    chk("rst_hit_valid", 32'(hit_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_armed", 32'(armed), 3);

    // Single fire
    threshold = 9'(10);
    step(1, 5, 0, 1, 0);
    chk("single_nofire", 32'(hit_valid), 0);
    step(1, 12, 0, 0, 0);
    chk("single_hv", 32'(hit_valid), 1);
    chk("single_hit", 32'(hit), 1);
    chk("single_armed", 32'(armed), 2);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("single_drain", 32'(hit_valid), 0);

    // Holdoff and re-arm
    step(0, 0, 0, 1, 1);
    step(1, 12, 0, 1, 0);
    for (int k = 0; k < HO; k++) step(1, 12, 0, 1, 0);
    chk("hold_nofire", 32'(hit_valid), 0);
    step(1, 9, 0, 1, 0);
`ifdef CHN_TRIGGER_HYST_EN
    chk("hyst_9_noarm", 32'(armed[0]), 0);
    step(1, 12, 0, 1, 0);
    chk("hyst_12_nofire", 32'(hit_valid), 0);
    step(1, 7, 0, 1, 0);
    chk("hyst_7_arm", 32'(armed[0]), 1);
    step(1, 10, 0, 1, 0);
    chk("hyst_10_fire", 32'(hit_valid), 1);
`else
    chk("nohyst_9_arm", 32'(armed[0]), 1);
    step(1, 12, 0, 1, 0);
    chk("nohyst_12_fire", 32'(hit_valid), 1);
`endif
    chk("rearm_hit", 32'(hit), 1);

    // Signed compare
    step(0, 0, 0, 1, 1);
    threshold = 9'(-3);
    step(1, -10, -2, 1, 0);
    chk("signed_fire_hit", 32'(hit), 2);
    chk("signed_fire_hv", 32'(hit_valid), 1);
    step(0, 0, 0, 1, 1);
    step(1, -10, -4, 1, 0);
    chk("signed_nofire", 32'(hit_valid), 0);
    chk("signed_armed", 32'(armed), 3);

    // Backpressure
    step(0, 0, 0, 1, 1);
    threshold = 9'(10);
    step(1, 12, 0, 0, 0);
    step(1, 0, 12, 0, 0);
    chk("bp_held_hit", 32'(hit), 1);
    chk("bp_held_hv", 32'(hit_valid), 1);
    step(0, 0, 0, 1, 0);
    chk("bp_next_hit", 32'(hit), 2);
    chk("bp_next_hv", 32'(hit_valid), 1);
    chk("bp_ovf", 32'(overflow), 0);
    step(0, 0, 0, 1, 0);
    chk("bp_drain", 32'(hit_valid), 0);

    // Overflow: third ch0 fire while the second still sits in pending
    step(0, 0, 0, 1, 1);
    step(1, 12, 0, 0, 0);
    for (int k = 0; k <= HO; k++) step(1, 0, 0, 0, 0);
    step(1, 12, 0, 0, 0);
    chk("ovf_first_pending", 32'(overflow), 0);
    for (int k = 0; k <= HO; k++) step(1, 0, 0, 0, 0);
    step(1, 12, 0, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("ovf_sticky", 32'(overflow), 1);
    step(0, 0, 0, 1, 1);
    chk("ovf_reset", 32'(overflow), 0);

    // Mid-operation reset
    step(1, 12, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("mid_pre_hv", 32'(hit_valid), 1);
    step(1, 12, 12, 1, 1);
    chk("mid_rst_hv", 32'(hit_valid), 0);
    chk("mid_rst_armed", 32'(armed), 3);
    step(1, 12, 0, 0, 0);
    chk("mid_refire_hv", 32'(hit_valid), 1);
    chk("mid_refire_hit", 32'(hit), 1);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) threshold = 9'(int'($urandom_range(0, 40)) - 20);
      t = $signed(threshold);
      step($urandom_range(0, 9) < 7,
           t + int'($urandom_range(0, 24)) - 12,
           t + int'($urandom_range(0, 24)) - 12,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 399) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
